// File: rtl/wb_cmd_pkg.sv
// wb_cmd_pkg: shared opcodes, response codes, error payloads and FSM states for wb_cmd_exec
package wb_cmd_pkg;
   localparam logic [1:0] OP_READ    = 2'b00;
   localparam logic [1:0] OP_WRITE   = 2'b01;
   localparam logic [1:0] OP_SETADDR = 2'b10;
   localparam logic [1:0] OP_NOP     = 2'b11;
   localparam logic [1:0] RSP_ADDR  = 2'b00;
   localparam logic [1:0] RSP_RDATA = 2'b01;
   localparam logic [1:0] RSP_WACK  = 2'b10;
   localparam logic [1:0] RSP_ERR   = 2'b11;
   localparam logic [31:0] ERR_BUS     = 32'h0000_0001;
   localparam logic [31:0] ERR_TIMEOUT = 32'h0000_0002;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/wb_exec_watchdog.sv
// wb_exec_watchdog: bus-cycle watchdog; expire is high on the LIMIT-th consecutive enabled cycle
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart count from zero
//   en       : count this cycle
//   expire   : combinational, en high and LIMIT-1 cycles already counted
module wb_exec_watchdog #(
   parameter int LIMIT = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int W = $clog2(LIMIT + 1);
   logic [W-1:0] cnt;
   assign expire = en && (cnt == W'(LIMIT - 1));
   always_ff @(posedge clk) begin
      if (rst || clr) cnt <= '0;
      else if (en) cnt <= cnt + W'(1);
   end
endmodule

// File: rtl/wb_cmd_exec.sv
// wb_cmd_exec: executes host command words as single classic-pipelined Wishbone cycles
//   clk, rst            : clock, synchronous active-high reset
//   i_cmd_stb/_word     : command strobe (rising edge accepts) and {op, payload}
//   o_busy, o_cmd_drop  : busy from accept through response; pulse when a command is discarded
//   o_wb_* / i_wb_*     : Wishbone master port (sel fixed at 4'hF)
//   o_rsp_stb/_word     : one-cycle response pulse and held response word
//   WB_EXEC_TIMEOUT_EN  : when defined, abort bus cycles after TIMEOUT_CYCLES with an error response
module wb_cmd_exec import wb_cmd_pkg::*; #(
   parameter int ADDR_WIDTH     = 30,
   parameter bit AUTO_INC       = 1'b1,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_cmd_stb,
   input  logic [33:0]           i_cmd_word,
   output logic                  o_busy,
   output logic                  o_cmd_drop,
   output logic                  o_wb_cyc,
   output logic                  o_wb_stb,
   output logic                  o_wb_we,
   output logic [ADDR_WIDTH-1:0] o_wb_addr,
   output logic [31:0]           o_wb_data,
   output logic [3:0]            o_wb_sel,
   input  logic                  i_wb_stall,
   input  logic                  i_wb_ack,
   input  logic                  i_wb_err,
   input  logic [31:0]           i_wb_data,
   output logic                  o_rsp_stb,
   output logic [33:0]           o_rsp_word
);
   state_t state, state_nx;
   logic stb_q, acc, bus_op, done, expire;
   logic [1:0] op;
   assign op = i_cmd_word[33:32];
   assign acc = i_cmd_stb && !stb_q;
   assign bus_op = (op == OP_READ) || (op == OP_WRITE);
   assign o_wb_cyc = (state == S_REQ) || (state == S_WAIT);
   assign o_wb_stb = state == S_REQ;
   assign o_wb_sel = 4'hF;
   assign o_rsp_stb = state == S_RESP;
   assign o_busy = state != S_IDLE;
   // ack/err are honoured in REQ even while stalled; anything outside a bus cycle is ignored
   assign done = o_wb_cyc && (i_wb_ack || i_wb_err || expire);
`ifdef WB_EXEC_TIMEOUT_EN
   wb_exec_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdg (
      .clk(clk), .rst(rst), .clr(!o_wb_cyc), .en(o_wb_cyc), .expire(expire)
   );
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign expire = 1'b0;
`endif
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  state_nx = !acc ? S_IDLE : bus_op ? S_REQ : (op == OP_SETADDR) ? S_RESP : S_IDLE;
         S_REQ:   state_nx = done ? S_RESP : !i_wb_stall ? S_WAIT : S_REQ;
         S_WAIT:  state_nx = done ? S_RESP : S_WAIT;
         S_RESP:  state_nx = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         stb_q      <= 1'b0;
         o_cmd_drop <= 1'b0;
         o_wb_we    <= 1'b0;
         o_wb_addr  <= '0;
         o_wb_data  <= '0;
         o_rsp_word <= '0;
      end else begin
         state      <= state_nx;
         stb_q      <= i_cmd_stb;
         o_cmd_drop <= acc && (state != S_IDLE);
         if (state == S_IDLE && acc && bus_op) begin
            o_wb_we   <= op == OP_WRITE;
            o_wb_data <= i_cmd_word[31:0];
         end
         if (state == S_IDLE && acc && op == OP_SETADDR) begin
            o_wb_addr  <= i_cmd_word[ADDR_WIDTH-1:0];
            o_rsp_word <= {RSP_ADDR, 32'(i_cmd_word[ADDR_WIDTH-1:0])};
         end
         if (done) begin
            o_rsp_word <= i_wb_err ? {RSP_ERR, ERR_BUS} :
                          !i_wb_ack ? {RSP_ERR, ERR_TIMEOUT} :
                          o_wb_we ? {RSP_WACK, 32'h0} : {RSP_RDATA, i_wb_data};
            if (i_wb_ack && !i_wb_err && AUTO_INC) o_wb_addr <= o_wb_addr + ADDR_WIDTH'(1);
         end
      end
   end
endmodule

// File: tb/tb_wb_cmd_exec.sv
// tb_wb_cmd_exec: scoreboard bench for wb_cmd_exec with a scripted Wishbone slave and reference model
module tb_wb_cmd_exec;
   logic clk = 1'b0, rst = 1'b1;
   logic i_cmd_stb = 1'b0;
   logic [33:0] i_cmd_word = '0;
   logic o_busy, o_cmd_drop, o_wb_cyc, o_wb_stb, o_wb_we, o_rsp_stb;
   logic [29:0] o_wb_addr;
   logic [31:0] o_wb_data;
   logic [3:0] o_wb_sel;
   logic i_wb_stall, i_wb_ack, i_wb_err;
   logic [31:0] i_wb_data;
   logic [33:0] o_rsp_word;

   wb_cmd_exec #(.ADDR_WIDTH(30), .AUTO_INC(1'b1), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .i_cmd_stb(i_cmd_stb), .i_cmd_word(i_cmd_word),
      .o_busy(o_busy), .o_cmd_drop(o_cmd_drop), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
      .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
      .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data),
      .o_rsp_stb(o_rsp_stb), .o_rsp_word(o_rsp_word)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int stb_cyc = 0, cyc_cyc = 0, drop_cnt = 0;
   logic [33:0] rq[$];
   logic [63:0] bq[$];
   logic [29:0] m_addr = '0;

   int stall_left = 0, s_delay = 0, cnt = 0;
   bit s_err = 0, s_hang = 0, pend = 0;
   logic [31:0] s_data = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // scripted slave: stalls stall_left cycles, then acks/errs s_delay cycles after acceptance
   initial begin
      i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0; i_wb_data = '0;
      forever begin
         @(posedge clk); #1;
         i_wb_ack = 0; i_wb_err = 0; i_wb_stall = 0;
         if (pend) begin
            if (cnt == 0) begin
               if (s_err) i_wb_err = 1; else begin i_wb_ack = 1; i_wb_data = s_data; end
               pend = 0;
            end else cnt--;
         end else if (o_wb_stb) begin
            if (stall_left > 0) begin i_wb_stall = 1; stall_left--; end
            else begin pend = !s_hang; cnt = s_delay; end
         end
      end
   end

   always @(negedge clk) begin
      if (o_wb_stb) stb_cyc++;
      if (o_wb_cyc) cyc_cyc++;
      if (o_cmd_drop) drop_cnt++;
      if (o_rsp_stb) begin
         if (rq.size() == 0) begin
            checks++; failures++;
            $display("FAIL rsp_unexpected actual=%h required=none", o_rsp_word);
         end else chk("rsp_word", 64'(o_rsp_word), 64'(rq.pop_front()));
      end
      if (o_wb_stb && !i_wb_stall) begin
         if (bq.size() == 0) begin
            checks++; failures++;
            $display("FAIL bus_unexpected actual=%h required=none", o_wb_addr);
         end else begin
            logic [63:0] e;
            e = bq.pop_front();
            chk("bus_we", 64'(o_wb_we), 64'(e[63]));
            chk("bus_addr", 64'(o_wb_addr), 64'(e[61:32]));
            chk("bus_sel", 64'(o_wb_sel), 64'hF);
            if (e[62]) chk("bus_data", 64'(o_wb_data), 64'(e[31:0]));
         end
      end
   end

   // model: push expected bus access and response for one command
   task automatic expect_cmd(input logic [1:0] op, input logic [31:0] pl, input bit er, input logic [31:0] rd, input bit tmo);
      if (op == 2'b00 || op == 2'b01) begin
         bq.push_back({op == 2'b01, op == 2'b01, m_addr, pl});
         rq.push_back(tmo ? {2'b11, 32'h2} : er ? {2'b11, 32'h1} : (op == 2'b01) ? {2'b10, 32'h0} : {2'b01, rd});
         if (!er && !tmo) m_addr = m_addr + 30'd1;
      end else if (op == 2'b10) begin
         m_addr = pl[29:0];
         rq.push_back({4'b0000, pl[29:0]});
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] pl, input int hold, input int stl,
                        input int dly, input bit er, input logic [31:0] rd, output int lat);
      bit fin = 0;
      expect_cmd(op, pl, er, rd, s_hang);
      stall_left = stl; s_delay = dly; s_err = er; s_data = rd;
      i_cmd_stb = 1; i_cmd_word = {op, pl}; lat = -1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk); #1;
         if (k == hold) i_cmd_stb = 0;
         if (o_rsp_stb && lat < 0) lat = k;
         if (k > hold && !o_busy) begin fin = 1; break; end
      end
      if (!fin) begin
         checks++; failures++;
         $display("FAIL cmd_timeout actual=busy required=idle");
         i_cmd_stb = 0;
      end
   endtask

   initial begin
      int lat, s0, c0, d0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      chk("reset_ctrl", 64'({o_busy, o_cmd_drop, o_wb_cyc, o_wb_stb, o_wb_we, o_rsp_stb}), 64'h0);
      chk("reset_addr", 64'(o_wb_addr), 64'h0);
      chk("reset_rsp", 64'(o_rsp_word), 64'h0);
      // SETADDR with strobe held two cycles
      c0 = cyc_cyc; d0 = drop_cnt;
      issue(2'b10, 32'h0000_0001, 2, 0, 0, 0, '0, lat);
      chk("setaddr_lat", 64'(lat), 64'd1);
      chk("setaddr_nocyc", 64'(cyc_cyc - c0), 64'd0);
      chk("setaddr_nodrop", 64'(drop_cnt - d0), 64'd0);
      // zero-wait write
      s0 = stb_cyc;
      issue(2'b01, 32'hDEAD_BEEF, 1, 0, 0, 0, '0, lat);
      chk("write_lat", 64'(lat), 64'd3);
      chk("write_stb_cycles", 64'(stb_cyc - s0), 64'd1);
      // stalled read
      s0 = stb_cyc;
      issue(2'b00, 32'h0, 1, 3, 2, 0, 32'h1234_5678, lat);
      chk("read_stb_cycles", 64'(stb_cyc - s0), 64'd4);
      // second command edge while waiting
      d0 = drop_cnt;
      expect_cmd(2'b00, 32'h0, 0, 32'hCAFE_F00D, 0);
      stall_left = 0; s_delay = 4; s_err = 0; s_data = 32'hCAFE_F00D;
      i_cmd_stb = 1; i_cmd_word = {2'b00, 32'h0};
      @(posedge clk); #1 i_cmd_stb = 0;
      @(posedge clk); #1 i_cmd_stb = 1; i_cmd_word = {2'b01, 32'h5555_AAAA};
      @(posedge clk); #1 i_cmd_stb = 0;
      for (int k = 0; k < 50 && o_busy; k++) begin @(posedge clk); #1; end
      chk("drop_once", 64'(drop_cnt - d0), 64'd1);
      // bus error read leaves address, following read confirms
      issue(2'b00, 32'h0, 1, 0, 1, 1, '0, lat);
      issue(2'b00, 32'h0, 1, 0, 0, 0, 32'h0BAD_F00D, lat);
      // address wrap
      issue(2'b10, 32'h3FFF_FFFF, 1, 0, 0, 0, '0, lat);
      issue(2'b00, 32'h0, 1, 0, 0, 0, 32'h1111_2222, lat);
      issue(2'b01, 32'h7777_8888, 1, 0, 0, 0, '0, lat);
`ifdef WB_EXEC_TIMEOUT_EN
      c0 = cyc_cyc; s_hang = 1;
      issue(2'b00, 32'h0, 1, 0, 0, 0, '0, lat);
      s_hang = 0;
      chk("timeout_cyc_cycles", 64'(cyc_cyc - c0), 64'd16);
`endif
      // reset while waiting on a slave that never answers
      s_hang = 1; stall_left = 0;
      bq.push_back({2'b00, m_addr, 32'h0});
      i_cmd_stb = 1; i_cmd_word = {2'b00, 32'h0};
      @(posedge clk); #1 i_cmd_stb = 0;
      @(posedge clk); #1;
      chk("wait_state", 64'({o_wb_cyc, o_wb_stb}), 64'b10);
      rst = 1;
      @(posedge clk); #1 rst = 0;
      chk("midrst_ctrl", 64'({o_busy, o_cmd_drop, o_wb_cyc, o_wb_stb, o_wb_we, o_rsp_stb}), 64'h0);
      chk("midrst_addr_data", 64'({o_wb_addr, o_wb_data}), 64'h0);
      chk("midrst_rsp", 64'(o_rsp_word), 64'h0);
      repeat (3) @(posedge clk);
      #1 s_hang = 0; m_addr = '0;
      // randomized traffic
      for (int n = 0; n < 150; n++)
         issue(2'($urandom_range(0, 3)), $urandom, $urandom_range(1, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom, lat);
      repeat (4) @(posedge clk);
      chk("rsp_queue_empty", 64'(rq.size()), 64'd0);
      chk("bus_queue_empty", 64'(bq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
